// File: rtl/mem_access.sv
// Memory-access stage: single-outstanding req/ack data-memory port for loads/stores,
// byte-lane alignment, load extension, fault detection and one registered writeback per instruction.
`timescale 1ns/1ps
module mem_access #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ex_valid_i,
   input  logic [31:0]     ex_instr_i,
   input  logic [XLEN-1:0] ex_alu_out_i,
   input  logic            ex_rd_wr_i,
   input  logic [XLEN-1:0] ex_store_data_i,
   output logic            ex_ready_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [3:0]      dmem_be_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   input  logic            dmem_ack_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            wb_valid_o,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            wb_rd_wr_o,
   output logic            wb_exc_o
);
   // state  | meaning
   // S_IDLE | ready to accept; non-memory and faulting ops retire from here
   // S_WAIT | bus request outstanding, waiting for dmem_ack_i
   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      f3_q, f3_d;
   logic [4:0]      rd_q, rd_d;
   logic            rd_wr_q, rd_wr_d;
   logic            wb_valid_q, wb_valid_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            wb_rd_wr_q, wb_rd_wr_d;
   logic            wb_exc_q, wb_exc_d;

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [4:0]      rd;
   logic            is_load, is_store, illegal, misaligned, accept;
   logic [3:0]      store_be;
   logic [XLEN-1:0] store_wdata, shifted, load_val;
   logic            unused_instr_bits;

   assign opcode            = ex_instr_i[6:0];
   assign f3                = ex_instr_i[14:12];
   assign rd                = ex_instr_i[11:7];
   assign unused_instr_bits = ^ex_instr_i[31:15];

   assign is_load    = (opcode == OP_LOAD);
   assign is_store   = (opcode == OP_STORE);
   assign illegal    = (is_load  && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
                       (is_store && (f3 >= 3'd3));
   // funct3[1:0] encodes access size for both loads and stores
   assign misaligned = ((f3[1:0] == 2'd1) && ex_alu_out_i[0]) ||
                       ((f3[1:0] == 2'd2) && (ex_alu_out_i[1:0] != 2'b00));

   assign ex_ready_o = (state_q == S_IDLE) && !rst_i;
   assign accept     = ex_valid_i && ex_ready_o;

   always_comb begin
      store_be    = 4'hF;
      store_wdata = ex_store_data_i;
      case (f3[1:0])
         2'd0: begin
            store_be    = 4'b0001 << ex_alu_out_i[1:0];
            store_wdata = {4{ex_store_data_i[7:0]}};
         end
         2'd1: begin
            store_be    = 4'b0011 << ex_alu_out_i[1:0];
            store_wdata = {2{ex_store_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_val = shifted;
      case (f3_q)
         3'd0:    load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'd1:    load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'd4:    load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'd5:    load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
      rd_wr_d    = rd_wr_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_rd_wr_d = wb_rd_wr_q;
      wb_exc_d   = wb_exc_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!is_load && !is_store) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd;
                  wb_data_d  = ex_alu_out_i;
                  wb_rd_wr_d = ex_rd_wr_i;
                  wb_exc_d   = 1'b0;
               end else if (illegal || misaligned) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd;
                  wb_data_d  = ex_alu_out_i;
                  wb_rd_wr_d = 1'b0;
                  wb_exc_d   = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  we_d    = is_store;
                  addr_d  = ex_alu_out_i;
                  be_d    = is_store ? store_be : 4'hF;
                  wdata_d = is_store ? store_wdata : wdata_q;
                  f3_d    = f3;
                  rd_d    = rd;
                  rd_wr_d = ex_rd_wr_i;
               end
            end
         end
         S_WAIT: begin
            if (dmem_ack_i) begin
               state_d    = S_IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_exc_d   = 1'b0;
               wb_rd_wr_d = we_q ? 1'b0 : rd_wr_q;
               wb_data_d  = we_q ? addr_q : load_val;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         rd_wr_q    <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_rd_wr_q <= 1'b0;
         wb_exc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
         rd_wr_q    <= rd_wr_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_rd_wr_q <= wb_rd_wr_d;
         wb_exc_q   <= wb_exc_d;
      end
   end

   // The request is the WAIT state itself, so an async reset withdraws it immediately.
   assign dmem_req_o   = (state_q == S_WAIT);
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;
   assign wb_valid_o   = wb_valid_q;
   assign wb_rd_o      = wb_rd_q;
   assign wb_data_o    = wb_data_q;
   assign wb_rd_wr_o   = wb_rd_wr_q;
   assign wb_exc_o     = wb_exc_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed and random instructions scored against a
// transaction-level model of the stage's results and bus requests.
`timescale 1ns/1ps
module tb_mem_access;
   localparam logic [6:0] OP_ALU   = 7'h33;
   localparam logic [6:0] OP_ALUI  = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_STORE = 7'h23;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_instr, ex_alu_out, ex_store_data;
   logic        ex_rd_wr, ex_ready;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_rd_wr, wb_exc;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   mem_access #(.XLEN(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .ex_valid_i(ex_valid), .ex_instr_i(ex_instr), .ex_alu_out_i(ex_alu_out),
      .ex_rd_wr_i(ex_rd_wr), .ex_store_data_i(ex_store_data), .ex_ready_o(ex_ready),
      .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
      .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_ack_i(dmem_ack),
      .dmem_rdata_i(dmem_rdata), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd),
      .wb_data_o(wb_data), .wb_rd_wr_o(wb_rd_wr), .wb_exc_o(wb_exc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          when;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        rd_wr;
      logic        exc;
   } wb_t;

   typedef struct {
      bit          mem;
      bit          fault;
      bit          we;
      logic [31:0] word_addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] wb_data;
      bit          wb_rd_wr;
   } pred_t;

   wb_t         exp_q[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        exp_req = 1'b0;
   logic        exp_we = 1'b0;
   logic [31:0] exp_addr = '0, exp_wdata = '0;
   logic [3:0]  exp_be = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // Outcome of one instruction from the architectural rules: access size
   // 1<<funct3[1:0], alignment as addr % size, lanes computed byte by byte.
   function automatic pred_t predict(input logic [6:0] op, input int f3, input logic [31:0] addr,
                                     input bit rd_wr, input logic [31:0] sd, input logic [31:0] rdata);
      pred_t p;
      int size, o;
      bit is_ld, is_st, illegal;
      longint unsigned raw, mask;
      p = '{default: 0};
      is_ld = (op == OP_LOAD);
      is_st = (op == OP_STORE);
      o     = int'(addr % 4);
      size  = 1 << (f3 % 4);
      if (!is_ld && !is_st) begin
         p.wb_data  = addr;
         p.wb_rd_wr = rd_wr;
         return p;
      end
      illegal = is_ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 >= 3);
      if (illegal || (addr % size) != 0) begin
         p.fault   = 1;
         p.wb_data = addr;
         return p;
      end
      p.mem       = 1;
      p.we        = is_st;
      p.word_addr = addr - o;
      if (is_st) begin
         p.be = 4'(((1 << size) - 1) << o);
         for (int lane = 0; lane < 4; lane++)
            p.wdata[8*lane +: 8] = sd[8*(lane % size) +: 8];
         p.wb_data = addr;
      end else begin
         p.be = 4'hF;
         raw  = longint'(rdata) >> (8 * o);
         mask = (64'd1 << (8 * size)) - 1;
         raw  = raw & mask;
         if (f3 < 4 && size < 4 && raw[8*size-1])
            raw = raw - (64'd1 << (8 * size));
         p.wb_data  = 32'(raw);
         p.wb_rd_wr = rd_wr;
      end
      return p;
   endfunction

   // Per-cycle compare, 1ns after each rising edge.
   always @(posedge clk) begin
      bit due;
      cyc = cyc + 1;
      #1;
      if (rst) begin
         chk("ex_ready_in_reset", ex_ready, 0);
         chk("dmem_req_in_reset", dmem_req, 0);
         chk("wb_valid_in_reset", wb_valid, 0);
      end else begin
         chk("ex_ready", ex_ready, !exp_req);
         chk("dmem_req", dmem_req, exp_req);
         if (exp_req) begin
            chk("dmem_we", dmem_we, exp_we);
            chk("dmem_addr", dmem_addr, exp_addr);
            chk("dmem_be", dmem_be, exp_be);
            if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
         end
         due = (exp_q.size() > 0) && (exp_q[0].when == cyc);
         chk("wb_valid", wb_valid, due);
         if (due) begin
            if (wb_valid) begin
               chk("wb_rd", wb_rd, exp_q[0].rd);
               chk("wb_data", wb_data, exp_q[0].data);
               chk("wb_rd_wr", wb_rd_wr, exp_q[0].rd_wr);
               chk("wb_exc", wb_exc, exp_q[0].exc);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      ex_valid   = 1'b0;
      ex_instr   = $urandom;
      dmem_ack   = 1'($urandom % 2);
      dmem_rdata = $urandom;
   endtask

   // Presents one instruction; for a bus access, acks after d wait cycles.
   task automatic issue(input logic [6:0] op, input int f3, input logic [4:0] rd,
                        input logic [31:0] alu, input bit rd_wr, input logic [31:0] sd,
                        input int d, input logic [31:0] rdata);
      pred_t p;
      @(negedge clk);
      dmem_ack      = 1'($urandom % 2);
      dmem_rdata    = $urandom;
      ex_valid      = 1'b1;
      ex_instr      = {17'($urandom), 3'(f3), rd, op};
      ex_alu_out    = alu;
      ex_rd_wr      = rd_wr;
      ex_store_data = sd;
      p = predict(op, f3, alu, rd_wr, sd, rdata);
      if (!p.mem) begin
         exp_q.push_back('{when: cyc + 1, rd: rd, data: p.wb_data, rd_wr: p.wb_rd_wr, exc: p.fault});
      end else begin
         exp_req   = 1'b1;
         exp_we    = p.we;
         exp_addr  = p.word_addr;
         exp_be    = p.be;
         exp_wdata = p.wdata;
         for (int i = 0; i <= d; i++) begin
            @(negedge clk);
            ex_valid   = 1'($urandom % 2);
            ex_instr   = $urandom;
            dmem_ack   = (i == d);
            dmem_rdata = (i == d) ? rdata : $urandom;
            if (i == d) begin
               exp_req = 1'b0;
               exp_q.push_back('{when: cyc + 1, rd: rd, data: p.wb_data, rd_wr: p.wb_rd_wr, exc: 1'b0});
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      pred_t pin;
      logic [6:0] op;
      int f3, d;
      logic [31:0] a;

      rst = 1'b1; ex_valid = 1'b0; ex_instr = '0; ex_alu_out = '0; ex_rd_wr = 1'b0;
      ex_store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_we", dmem_we, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_dmem_be", dmem_be, 0);
      chk("rst_dmem_wdata", dmem_wdata, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd_wr", wb_rd_wr, 0);
      chk("rst_wb_exc", wb_exc, 0);
      chk("rst_ex_ready", ex_ready, 0);
      rst = 1'b0;

      // Pin the model against hand-computed values.
      pin = predict(OP_LOAD, 0, 32'h103, 1, 0, 32'h80FF_1234);
      chk("pin_lb_data", pin.wb_data, 32'hFFFF_FF80);
      chk("pin_lb_addr", pin.word_addr, 32'h100);
      pin = predict(OP_LOAD, 4, 32'h103, 1, 0, 32'h80FF_1234);
      chk("pin_lbu_data", pin.wb_data, 32'h0000_0080);
      pin = predict(OP_STORE, 1, 32'h202, 0, 32'hDEAD_BEEF, 0);
      chk("pin_sh_be", pin.be, 4'b1100);
      chk("pin_sh_wdata", pin.wdata, 32'hBEEF_BEEF);
      pin = predict(OP_LOAD, 2, 32'h101, 1, 0, 0);
      chk("pin_lw_fault", pin.fault, 1);
      pin = predict(OP_STORE, 1, 32'h203, 0, 0, 0);
      chk("pin_sh_fault", pin.fault, 1);

      // ALU ops, three back-to-back.
      issue(OP_ALU, 0, 5'd5, 32'h42, 1, 0, 0, 0);
      issue(OP_ALU, 0, 5'd6, 32'h1234_5678, 1, 0, 0, 0);
      issue(OP_ALUI, 3, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0);
      idle();
      chk("add_wb_data_literal", wb_data, 32'hFFFF_FFFF);

      issue(OP_LOAD, 0, 5'd7, 32'h103, 1, 0, 3, 32'h80FF_1234);
      issue(OP_LOAD, 4, 5'd8, 32'h103, 1, 0, 1, 32'h80FF_1234);
      issue(OP_STORE, 1, 5'd9, 32'h202, 1, 32'hDEAD_BEEF, 1, 0);
      issue(OP_LOAD, 2, 5'd10, 32'h101, 1, 0, 0, 0);
      issue(OP_STORE, 1, 5'd11, 32'h203, 1, 32'h1111_2222, 0, 0);
      idle();
      // Ack in the first request cycle, then an ALU op right behind it.
      issue(OP_LOAD, 2, 5'd12, 32'h400, 1, 0, 0, 32'hCAFE_F00D);
      issue(OP_ALU, 0, 5'd13, 32'h77, 1, 0, 0, 0);
      idle();

      // Reset while a load is waiting.
      @(negedge clk);
      ex_valid = 1'b1; ex_instr = {17'h0, 3'd2, 5'd14, OP_LOAD}; ex_alu_out = 32'h300;
      ex_rd_wr = 1'b1; dmem_ack = 1'b0;
      exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF;
      @(negedge clk);
      ex_valid = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      exp_req = 1'b0;
      #1;
      chk("rst_wait_dmem_req", dmem_req, 0);
      chk("rst_wait_ex_ready", ex_ready, 0);
      chk("rst_wait_dmem_addr", dmem_addr, 0);
      chk("rst_wait_dmem_be", dmem_be, 0);
      chk("rst_wait_wb_valid", wb_valid, 0);
      chk("rst_wait_wb_data", wb_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(OP_LOAD, 2, 5'd15, 32'h500, 1, 0, 2, 32'h0BAD_C0DE);
      idle();

      // Random mix.
      for (int n = 0; n < 400; n++) begin
         case ($urandom % 4)
            0:       op = OP_ALU;
            1:       op = OP_ALUI;
            2:       op = OP_LOAD;
            default: op = OP_STORE;
         endcase
         f3 = int'($urandom % 8);
         a  = $urandom;
         if ($urandom % 3 != 0) a[1:0] = (f3 % 4 == 2) ? 2'b00 : ((f3 % 4 == 1) ? {1'($urandom), 1'b0} : a[1:0]);
         d  = int'($urandom % 4);
         issue(op, f3, 5'($urandom), a, 1'($urandom), $urandom, d, $urandom);
         if ($urandom % 5 == 0) idle();
      end
      repeat (3) idle();
      chk("wb_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute ALU. Takes the ALU result (`c_out` = effective address for LOAD/STORE, final result otherwise) plus store data, and runs a single-outstanding req/ack transaction on the data-memory port for loads and stores. It aligns store bytes, extracts and sign/zero-extends load data, flags misaligned or illegal accesses, and presents one registered result per instruction to writeback. It stalls the execute stage while a bus transaction is pending.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; everything samples on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ex_valid`  in  1  execute stage presents an instruction.
- `ex_instr`  in  32  instruction word (`instr_t`): opcode, funct3, rd[11:7].
- `ex_alu_out`  in  32  ALU `c_out`.
- `ex_rd_wr`  in  1  ALU `rd_wr`.
- `ex_store_data`  in  32  rs2 value.
- `ex_ready`  out  1  stage can accept; the instruction is accepted when `ex_valid & ex_ready`.
- `dmem_req`  out  1  bus request; held until ack.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word address, bits [1:0] forced to 0.
- `dmem_be`  out  4  byte enables; all ones for loads.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ack`  in  1  completes the request; only meaningful while `dmem_req` is high.
- `dmem_rdata`  in  32  load word; valid in the ack cycle.
- `wb_valid`  out  1  one-cycle pulse: result available.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  result or extended load data.
- `wb_rd_wr`  out  1  register write enable.
- `wb_exc`  out  1  misaligned or illegal memory access.

## Operation
- FSM states:
  - IDLE: `ex_ready` = 1.
  - WAIT: bus pending, `ex_ready` = 0.
- Accept in IDLE, by instruction type:
  - Non-memory opcode: register `wb_data` = `ex_alu_out`, `wb_rd_wr` = `ex_rd_wr`, `wb_rd` = rd, `wb_valid` = 1 next cycle. Stay in IDLE.
  - LOAD/STORE, aligned and legal: next cycle drive `dmem_req` = 1 with `addr`, `we`, `be` and `wdata` registered. Go to WAIT.
  - LOAD/STORE, misaligned or illegal: no bus request. Next cycle `wb_valid` = 1, `wb_exc` = 1, `wb_rd_wr` = 0, `wb_data` = faulting address.
- Misaligned:
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] ≠ 0.
- Illegal: load funct3 ∈ {3, 6, 7}; store funct3 ≥ 3.
- Store lanes, with o = addr[1:0]:
  - SB: be = 4'b0001 << o, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << o, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- WAIT: `dmem_*` outputs stay stable until `dmem_ack`. On the ack edge, go to IDLE and clear `dmem_req`. Next cycle `wb_valid` = 1.
- Load result: shift `dmem_rdata` right by 8·o, then:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
  - `wb_rd_wr` = `ex_rd_wr`.
- Store result: `wb_rd_wr` = 0, `wb_data` = address.
- rd = 0 passes through unchanged; writeback ignores x0.

## Timing
- Reset values: `dmem_req`, `dmem_we`, `wb_valid`, `wb_rd_wr`, `wb_exc` = 0. `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_rd`, `wb_data` = 0. State = IDLE.
- `ex_ready` = 0 while `rst` is high.
- Latency:
  - Non-memory and exception: accept edge N, `wb_valid` at N+1. Back-to-back accepts every cycle.
  - Memory: accept N, `dmem_req` from N+1. Ack at cycle K ≥ N+1, `wb_valid` at K+1. Minimum 2 cycles accept→wb.
- `ex_ready` falls combinationally in WAIT; it returns to 1 in the cycle after the ack edge. Next accept earliest K+1.
- `wb_valid` is high exactly one cycle per accepted instruction. Writeback never stalls.
- `ex_valid` while `ex_ready` = 0 is ignored. Upstream holds the instruction.
- `dmem_ack` while `dmem_req` = 0 is ignored.
- Reset during WAIT: `dmem_req` drops asynchronously, no `wb_valid` is produced, and the transaction is abandoned. The memory must tolerate a withdrawn request.

## Test plan
- Reset, then ADD with `ex_alu_out` = 0x0000_0042, rd = 5, `ex_rd_wr` = 1 → next cycle `wb_valid` = 1, rd = 5, data = 0x42, `wb_rd_wr` = 1. Three back-to-back ALU ops → three consecutive wb pulses.
- LB at addr 0x103, ack after 3 wait cycles, rdata = 0x80FF_1234 → `dmem_addr` = 0x100, be = 0xF, `ex_ready` = 0 until ack, `wb_data` = 0xFFFF_FF80. LBU on the same data → 0x0000_0080.
- SH at addr 0x202, rs2 = 0xDEAD_BEEF → `dmem_we` = 1, be = 4'b1100, wdata = 0xBEEF_BEEF. After ack: `wb_valid` = 1, `wb_rd_wr` = 0.
- LW at 0x101 and SH at 0x203 → no `dmem_req`; `wb_exc` = 1 next cycle, `wb_data` = 0x101 / 0x203, `wb_rd_wr` = 0.
- Ack on the same cycle `dmem_req` first rises (K = N+1) → `wb_valid` at N+2. A following ALU op accepted at N+2 → its wb at N+3.
- Assert `rst` mid-WAIT → `dmem_req` drops in the same cycle, no `wb_valid`, all outputs at reset values. After release, an LW completes normally.
